// File: rtl/plan_select_seq.sv
// Streaming plan selector: scores each accepted plan against a latched profile and
// reports the best eligible plan (or the cheapest). Optional runner-up: PLAN_SELECT_RUNNERUP_EN.
module plan_select_seq #(
    parameter int unsigned DW        = 6,
    parameter int unsigned WW        = 3,
    parameter int unsigned MAX_PLANS = 16,
    parameter int unsigned IDXW      = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [DW-1:0]           budget,
    input  logic [DW-1:0]           avg_talk,
    input  logic [DW-1:0]           avg_data,
    input  logic [WW-1:0]           w_talk,
    input  logic [WW-1:0]           w_data,
    input  logic                    plan_valid,
    output logic                    plan_ready,
    input  logic [DW-1:0]           plan_cost,
    input  logic [DW-1:0]           plan_talk,
    input  logic [DW-1:0]           plan_data,
    input  logic                    plan_last,
    output logic                    busy,
    output logic                    result_valid,
    input  logic                    result_ready,
    output logic [IDXW-1:0]         best_idx,
    output logic [DW+WW:0]          best_score,
    output logic                    fallback,
    output logic                    truncated,
    output logic [IDXW:0]           plan_count,
    output logic [IDXW-1:0]         second_idx,
    output logic [DW+WW:0]          second_score
);
    localparam int unsigned SW = DW + WW + 1;

    typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

    state_e            state_q, state_d;
    logic [DW-1:0]     budget_q, budget_d, avg_talk_q, avg_talk_d, avg_data_q, avg_data_d;
    logic [WW-1:0]     w_talk_q, w_talk_d, w_data_q, w_data_d;
    logic [IDXW:0]     cnt_q, cnt_d;
    logic              has_elig_q, has_elig_d;
    logic [IDXW-1:0]   elig_idx_q, elig_idx_d, min_idx_q, min_idx_d, res_idx_q, res_idx_d;
    logic [SW-1:0]     elig_score_q, elig_score_d, res_score_q, res_score_d;
    logic [DW-1:0]     min_cost_q, min_cost_d;
    logic              res_fb_q, res_fb_d, res_trunc_q, res_trunc_d;

    logic              accept, eligible, at_max, is_last, new_best, new_min;
    logic [IDXW-1:0]   cur_idx;
    logic [SW-1:0]     cur_score;

    assign accept    = (state_q == StLoad) && plan_valid;
    assign cur_idx   = cnt_q[IDXW-1:0];
    assign cur_score = SW'(plan_talk) * SW'(w_talk_q) + SW'(plan_data) * SW'(w_data_q);
    assign eligible  = (plan_cost <= budget_q) && (plan_talk >= avg_talk_q) &&
                       (plan_data >= avg_data_q);
    assign at_max    = (cnt_q == (IDXW+1)'(MAX_PLANS - 1));
    assign is_last   = plan_last || at_max;
    assign new_best  = eligible && (!has_elig_q || (cur_score > elig_score_q));
    // First accepted plan always seeds the cheapest tracker.
    assign new_min   = (cnt_q == '0) || (plan_cost < min_cost_q);

    always_comb begin
        state_d      = state_q;
        budget_d     = budget_q;
        avg_talk_d   = avg_talk_q;
        avg_data_d   = avg_data_q;
        w_talk_d     = w_talk_q;
        w_data_d     = w_data_q;
        cnt_d        = cnt_q;
        has_elig_d   = has_elig_q;
        elig_idx_d   = elig_idx_q;
        elig_score_d = elig_score_q;
        min_cost_d   = min_cost_q;
        min_idx_d    = min_idx_q;
        res_idx_d    = res_idx_q;
        res_score_d  = res_score_q;
        res_fb_d     = res_fb_q;
        res_trunc_d  = res_trunc_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d      = StLoad;
                    budget_d     = budget;
                    avg_talk_d   = avg_talk;
                    avg_data_d   = avg_data;
                    w_talk_d     = w_talk;
                    w_data_d     = w_data;
                    cnt_d        = '0;
                    has_elig_d   = 1'b0;
                    elig_idx_d   = '0;
                    elig_score_d = '0;
                    min_cost_d   = '0;
                    min_idx_d    = '0;
                    res_idx_d    = '0;
                    res_score_d  = '0;
                    res_fb_d     = 1'b0;
                    res_trunc_d  = 1'b0;
                end
            end
            StLoad: begin
                if (accept) begin
                    cnt_d = cnt_q + (IDXW+1)'(1);
                    if (new_best) begin
                        has_elig_d   = 1'b1;
                        elig_idx_d   = cur_idx;
                        elig_score_d = cur_score;
                    end
                    if (new_min) begin
                        min_cost_d = plan_cost;
                        min_idx_d  = cur_idx;
                    end
                    if (is_last) begin
                        state_d     = StDone;
                        res_idx_d   = has_elig_d ? elig_idx_d : min_idx_d;
                        res_score_d = has_elig_d ? elig_score_d : '0;
                        res_fb_d    = !has_elig_d;
                        res_trunc_d = at_max && !plan_last;
                    end
                end
            end
            StDone: begin
                if (result_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            budget_q     <= '0;
            avg_talk_q   <= '0;
            avg_data_q   <= '0;
            w_talk_q     <= '0;
            w_data_q     <= '0;
            cnt_q        <= '0;
            has_elig_q   <= 1'b0;
            elig_idx_q   <= '0;
            elig_score_q <= '0;
            min_cost_q   <= '0;
            min_idx_q    <= '0;
            res_idx_q    <= '0;
            res_score_q  <= '0;
            res_fb_q     <= 1'b0;
            res_trunc_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            budget_q     <= budget_d;
            avg_talk_q   <= avg_talk_d;
            avg_data_q   <= avg_data_d;
            w_talk_q     <= w_talk_d;
            w_data_q     <= w_data_d;
            cnt_q        <= cnt_d;
            has_elig_q   <= has_elig_d;
            elig_idx_q   <= elig_idx_d;
            elig_score_q <= elig_score_d;
            min_cost_q   <= min_cost_d;
            min_idx_q    <= min_idx_d;
            res_idx_q    <= res_idx_d;
            res_score_q  <= res_score_d;
            res_fb_q     <= res_fb_d;
            res_trunc_q  <= res_trunc_d;
        end
    end

    assign plan_ready   = (state_q == StLoad);
    assign busy         = (state_q != StIdle);
    assign result_valid = (state_q == StDone);
    assign best_idx     = res_idx_q;
    assign best_score   = res_score_q;
    assign fallback     = res_fb_q;
    assign truncated    = res_trunc_q;
    assign plan_count   = cnt_q;

`ifdef PLAN_SELECT_RUNNERUP_EN
    logic            has_sec_q, has_sec_d;
    logic [IDXW-1:0] sec_idx_q, sec_idx_d, res_sidx_q, res_sidx_d;
    logic [SW-1:0]   sec_score_q, sec_score_d, res_sscore_q, res_sscore_d;

    always_comb begin
        has_sec_d    = has_sec_q;
        sec_idx_d    = sec_idx_q;
        sec_score_d  = sec_score_q;
        res_sidx_d   = res_sidx_q;
        res_sscore_d = res_sscore_q;
        if ((state_q == StIdle) && start) begin
            has_sec_d    = 1'b0;
            sec_idx_d    = '0;
            sec_score_d  = '0;
            res_sidx_d   = '0;
            res_sscore_d = '0;
        end else if (accept) begin
            // A new best pushes the previous best down into the runner-up slot.
            if (new_best) begin
                if (has_elig_q) begin
                    has_sec_d   = 1'b1;
                    sec_idx_d   = elig_idx_q;
                    sec_score_d = elig_score_q;
                end
            end else if (eligible && (!has_sec_q || (cur_score > sec_score_q))) begin
                has_sec_d   = 1'b1;
                sec_idx_d   = cur_idx;
                sec_score_d = cur_score;
            end
            if (is_last) begin
                res_sidx_d   = has_sec_d ? sec_idx_d : '0;
                res_sscore_d = has_sec_d ? sec_score_d : '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            has_sec_q    <= 1'b0;
            sec_idx_q    <= '0;
            sec_score_q  <= '0;
            res_sidx_q   <= '0;
            res_sscore_q <= '0;
        end else begin
            has_sec_q    <= has_sec_d;
            sec_idx_q    <= sec_idx_d;
            sec_score_q  <= sec_score_d;
            res_sidx_q   <= res_sidx_d;
            res_sscore_q <= res_sscore_d;
        end
    end

    assign second_idx   = res_sidx_q;
    assign second_score = res_sscore_q;
`else
    assign second_idx   = '0;
    assign second_score = '0;
`endif

endmodule

// File: tb/tb_plan_select_seq.sv
// Randomised scoreboard bench for plan_select_seq with a behavioural selection model.
module tb_plan_select_seq;
    localparam int DW = 6, WW = 3, MAXP = 16, IDXW = 4, SW = DW + WW + 1;

    logic clk = 1'b0;
    logic rst;
    logic start, plan_valid, plan_last, result_ready;
    logic [DW-1:0] budget, avg_talk, avg_data, plan_cost, plan_talk, plan_data;
    logic [WW-1:0] w_talk, w_data;
    logic plan_ready, busy, result_valid, fallback, truncated;
    logic [IDXW-1:0] best_idx, second_idx;
    logic [SW-1:0] best_score, second_score;
    logic [IDXW:0] plan_count;

    always #5 clk = ~clk;

    plan_select_seq #(.DW(DW), .WW(WW), .MAX_PLANS(MAXP), .IDXW(IDXW)) dut (
        .clk(clk), .rst(rst), .start(start), .budget(budget), .avg_talk(avg_talk),
        .avg_data(avg_data), .w_talk(w_talk), .w_data(w_data), .plan_valid(plan_valid),
        .plan_ready(plan_ready), .plan_cost(plan_cost), .plan_talk(plan_talk),
        .plan_data(plan_data), .plan_last(plan_last), .busy(busy), .result_valid(result_valid),
        .result_ready(result_ready), .best_idx(best_idx), .best_score(best_score),
        .fallback(fallback), .truncated(truncated), .plan_count(plan_count),
        .second_idx(second_idx), .second_score(second_score)
    );

    typedef struct {
        int idx; int score; int fb; int trunc; int cnt; int sidx; int sscore;
    } exp_t;
    exp_t expq[$];

    int vectors = 0, miscompares = 0;
    int pb, pat, pad, pwt, pwd;
    int pc[MAXP], pt[MAXP], pd[MAXP];

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Best = highest score, earliest index; cheapest = lowest cost, earliest index.
    function automatic void model(input int n, input bit last_flag);
        exp_t e;
        int best = -1, bsc = 0, cheap = 0, sec = -1, ssc = 0;
        int sc[MAXP];
        bit el[MAXP];
        for (int i = 0; i < n; i++) begin
            el[i] = (pc[i] <= pb) && (pt[i] >= pat) && (pd[i] >= pad);
            sc[i] = pt[i] * pwt + pd[i] * pwd;
            if (el[i] && (best < 0 || sc[i] > bsc)) begin best = i; bsc = sc[i]; end
            if (pc[i] < pc[cheap]) cheap = i;
        end
        for (int i = 0; i < n; i++)
            if (el[i] && i != best && (sec < 0 || sc[i] > ssc)) begin sec = i; ssc = sc[i]; end
        e.fb     = (best < 0) ? 1 : 0;
        e.idx    = (best < 0) ? cheap : best;
        e.score  = (best < 0) ? 0 : bsc;
        e.trunc  = (n == MAXP && !last_flag) ? 1 : 0;
        e.cnt    = n;
`ifdef PLAN_SELECT_RUNNERUP_EN
        e.sidx   = (sec < 0) ? 0 : sec;
        e.sscore = (sec < 0) ? 0 : ssc;
`else
        e.sidx   = 0;
        e.sscore = 0;
`endif
        expq.push_back(e);
    endfunction

    // Monitor: a handshake completes at the next rising edge when both are high here.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (result_valid && result_ready) begin
                if (expq.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_result: got result idx %0d expected none", best_idx);
                end else begin
                    e = expq.pop_front();
                    check("best_idx", int'(best_idx), e.idx);
                    check("best_score", int'(best_score), e.score);
                    check("fallback", int'(fallback), e.fb);
                    check("truncated", int'(truncated), e.trunc);
                    check("plan_count", int'(plan_count), e.cnt);
                    check("second_idx", int'(second_idx), e.sidx);
                    check("second_score", int'(second_score), e.sscore);
                end
            end
        end
    end

    task automatic begin_query();
        @(posedge clk); #1;
        start = 1'b1;
        budget = DW'(pb); avg_talk = DW'(pat); avg_data = DW'(pad);
        w_talk = WW'(pwt); w_data = WW'(pwd);
        @(posedge clk); #1;
        start = 1'b0;
        // Scramble profile inputs: the DUT must use the latched copy.
        budget = DW'($urandom); avg_talk = DW'($urandom); avg_data = DW'($urandom);
        w_talk = WW'($urandom); w_data = WW'($urandom);
        check("busy_in_load", int'(busy), 1);
    endtask

    task automatic run_query(input int n, input bit last_flag, input bit gaps, input int hold);
        logic [31:0] snap;
        model(n, last_flag);
        result_ready = (hold == 0);
        begin_query();
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                plan_valid = 1'b0; plan_last = 1'b1; plan_cost = DW'($urandom);
                @(posedge clk); #1;
            end
            plan_cost = DW'(pc[i]); plan_talk = DW'(pt[i]); plan_data = DW'(pd[i]);
            plan_last = last_flag && (i == n - 1);
            plan_valid = 1'b1;
            check("plan_ready_load", int'(plan_ready), 1);
            check("no_early_result", int'(result_valid), 0);
            @(posedge clk); #1;
        end
        plan_valid = 1'b0; plan_last = 1'b0;
        check("result_latency", int'(result_valid), 1);
        check("ready_low_done", int'(plan_ready), 0);
        if (hold > 0) begin
            snap = {best_idx, best_score, fallback, truncated, plan_count, second_idx};
            for (int k = 0; k < hold; k++) begin
                start = 1'b1; budget = DW'($urandom);
                @(posedge clk); #1;
                check("hold_stable", int'({best_idx, best_score, fallback, truncated,
                      plan_count, second_idx}), int'(snap));
                check("hold_valid", int'(result_valid), 1);
            end
            result_ready = 1'b1;
        end
        @(posedge clk); #1;
        start = 1'b0;
        check("idle_after_hs", int'(busy), 0);
        check("valid_dropped", int'(result_valid), 0);
        check("count_retained", int'(plan_count), n);
    endtask

    task automatic set_plan(input int i, input int c, input int t, input int d);
        pc[i] = c; pt[i] = t; pd[i] = d;
    endtask

    task automatic random_plans(input int n);
        for (int i = 0; i < n; i++)
            set_plan(i, $urandom_range(0, 63), $urandom_range(0, 63), $urandom_range(0, 63));
    endtask

    initial begin
        int n;
        bit lf;
        rst = 1'b1; start = 1'b0; plan_valid = 1'b0; plan_last = 1'b0; result_ready = 1'b0;
        budget = '0; avg_talk = '0; avg_data = '0; w_talk = '0; w_data = '0;
        plan_cost = '0; plan_talk = '0; plan_data = '0;
        #12;
        check("rst_busy", int'(busy), 0);
        check("rst_plan_ready", int'(plan_ready), 0);
        check("rst_result_valid", int'(result_valid), 0);
        check("rst_fields", int'({best_idx, best_score, fallback, truncated, plan_count}), 0);
        @(posedge clk); #1; rst = 1'b0;

        // Basic selection, with valid gaps.
        pb = 20; pat = 10; pad = 5; pwt = 2; pwd = 3;
        set_plan(0, 10, 20, 5); set_plan(1, 12, 10, 15); set_plan(2, 30, 40, 40);
        run_query(3, 1, 1, 0);
        // No plan eligible: fallback to cheapest.
        pb = 5;
        run_query(3, 1, 0, 0);
        // Equal scores, with result backpressure and ignored start pulses.
        pb = 10; pat = 0; pad = 0; pwt = 1; pwd = 1;
        set_plan(0, 5, 10, 10); set_plan(1, 5, 12, 8);
        run_query(2, 1, 0, 3);
        // Truncation at MAX_PLANS.
        pb = 40; pat = 20; pad = 20; pwt = 5; pwd = 6;
        random_plans(MAXP);
        run_query(MAXP, 0, 1, 0);
        // Zero weights: lowest eligible index wins with score 0.
        pb = 63; pat = 0; pad = 0; pwt = 0; pwd = 0;
        random_plans(5);
        run_query(5, 1, 0, 1);

        // Reset after two accepts discards the query.
        begin_query();
        for (int i = 0; i < 2; i++) begin
            plan_cost = DW'(i); plan_talk = 6'd9; plan_data = 6'd9; plan_valid = 1'b1;
            @(posedge clk); #1;
        end
        rst = 1'b1; #1;
        check("midrst_busy", int'(busy), 0);
        check("midrst_plan_ready", int'(plan_ready), 0);
        check("midrst_result_valid", int'(result_valid), 0);
        plan_valid = 1'b0;
        @(posedge clk); #1; rst = 1'b0;
        pb = 30; pat = 5; pad = 5; pwt = 3; pwd = 2;
        random_plans(4);
        run_query(4, 1, 0, 0);

        for (int q = 0; q < 30; q++) begin
            pb = $urandom_range(0, 63); pat = $urandom_range(0, 40); pad = $urandom_range(0, 40);
            pwt = $urandom_range(0, 7); pwd = $urandom_range(0, 7);
            n = $urandom_range(1, MAXP);
            lf = (n < MAXP) ? 1'b1 : 1'($urandom_range(0, 1));
            random_plans(n);
            run_query(n, lf, 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0);
        end

        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", expq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
